// File: rtl/vad_hangover_smoother.sv
// VAD decision smoother: onset confirmation and hangover hysteresis
// on the classifier's per-frame verdicts, with segment start/end events.
module vad_hangover_smoother #(
  parameter int ONSET_FRAMES = 3,
  parameter int HANG_FRAMES  = 4,
  parameter int SEG_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tvalid_prediction,
  input  logic             prediction,
  output logic             vad_active,
  output logic             vad_start,
  output logic             vad_end,
  output logic [SEG_W-1:0] seg_len
);

  localparam int ON_W = $clog2(ONSET_FRAMES + 1);
  localparam int HG_W = $clog2(HANG_FRAMES + 1);

  localparam logic [ON_W-1:0] ON_MAX = ON_W'(ONSET_FRAMES);
  localparam logic [HG_W-1:0] HG_MAX = HG_W'(HANG_FRAMES);

  localparam bit ONSET_ONE = (ONSET_FRAMES == 1);
  localparam bit HANG_ONE  = (HANG_FRAMES == 1);

  typedef enum logic [1:0] {
    IDLE,
    ONSET,
    SPEECH,
    HANG
  } state_e;

  state_e           state_q, state_d;
  logic [ON_W-1:0]  onset_cnt_q, onset_cnt_d;
  logic [HG_W-1:0]  hang_cnt_q, hang_cnt_d;
  logic [SEG_W-1:0] seg_cnt_q, seg_cnt_d;
  logic [SEG_W-1:0] seg_len_q, seg_len_d;
  logic             vad_active_q, vad_active_d;
  logic             vad_start_q, vad_start_d;
  logic             vad_end_q, vad_end_d;

  logic [ON_W-1:0]  onset_inc;
  logic [HG_W-1:0]  hang_inc;
  logic [SEG_W-1:0] seg_inc;
  logic             do_close;

  always_comb begin
    state_d     = state_q;
    onset_cnt_d = onset_cnt_q;
    hang_cnt_d  = hang_cnt_q;
    seg_cnt_d   = seg_cnt_q;
    seg_len_d   = seg_len_q;
    vad_start_d = 1'b0;
    vad_end_d   = 1'b0;
    do_close    = 1'b0;

    onset_inc = onset_cnt_q + ON_W'(1);
    hang_inc  = hang_cnt_q + HG_W'(1);
    // segment length saturates instead of wrapping
    seg_inc   = (seg_cnt_q == '1) ? seg_cnt_q
                                  : seg_cnt_q + SEG_W'(1);

    if (tvalid_prediction) begin
      unique case (state_q)
        IDLE: begin
          if (prediction) begin
            onset_cnt_d = ON_W'(1);
            seg_cnt_d   = SEG_W'(1);
            if (ONSET_ONE) begin
              state_d     = SPEECH;
              vad_start_d = 1'b1;
            end else begin
              state_d = ONSET;
            end
          end
        end
        ONSET: begin
          if (prediction) begin
            onset_cnt_d = onset_inc;
            seg_cnt_d   = seg_inc;
            if (onset_inc == ON_MAX) begin
              state_d     = SPEECH;
              vad_start_d = 1'b1;
            end
          end else begin
            state_d     = IDLE;
            onset_cnt_d = '0;
            seg_cnt_d   = '0;
          end
        end
        SPEECH: begin
          seg_cnt_d = seg_inc;
          if (!prediction) begin
            hang_cnt_d = HG_W'(1);
            if (HANG_ONE) begin
              do_close = 1'b1;
            end else begin
              state_d = HANG;
            end
          end
        end
        HANG: begin
          seg_cnt_d = seg_inc;
          if (prediction) begin
            state_d    = SPEECH;
            hang_cnt_d = '0;
          end else begin
            hang_cnt_d = hang_inc;
            if (hang_inc == HG_MAX) begin
              do_close = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // closing frame is included in the reported length
    if (do_close) begin
      state_d     = IDLE;
      vad_end_d   = 1'b1;
      seg_len_d   = seg_inc;
      seg_cnt_d   = '0;
      hang_cnt_d  = '0;
      onset_cnt_d = '0;
    end

    vad_active_d = (state_d == SPEECH) || (state_d == HANG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      onset_cnt_q  <= '0;
      hang_cnt_q   <= '0;
      seg_cnt_q    <= '0;
      seg_len_q    <= '0;
      vad_active_q <= 1'b0;
      vad_start_q  <= 1'b0;
      vad_end_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      onset_cnt_q  <= onset_cnt_d;
      hang_cnt_q   <= hang_cnt_d;
      seg_cnt_q    <= seg_cnt_d;
      seg_len_q    <= seg_len_d;
      vad_active_q <= vad_active_d;
      vad_start_q  <= vad_start_d;
      vad_end_q    <= vad_end_d;
    end
  end

  assign vad_active = vad_active_q;
  assign vad_start  = vad_start_q;
  assign vad_end    = vad_end_q;
  assign seg_len    = seg_len_q;

endmodule

// File: tb/tb_vad_hangover_smoother.sv
// Bench for vad_hangover_smoother: directed vector table, a saturation
// sequence on a narrow-counter instance, and randomized model checks.
module tb_vad_hangover_smoother;

  localparam int ONSET = 3;
  localparam int HANG  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid_prediction;
  logic        prediction;
  logic        act_a, start_a, end_a;
  logic [15:0] len_a;
  logic        act_b, start_b, end_b;
  logic [2:0]  len_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vad_hangover_smoother #(
    .ONSET_FRAMES(ONSET), .HANG_FRAMES(HANG), .SEG_W(16)
  ) dut_a (
    .clk(clk), .rst(rst),
    .tvalid_prediction(tvalid_prediction),
    .prediction(prediction),
    .vad_active(act_a), .vad_start(start_a),
    .vad_end(end_a), .seg_len(len_a)
  );

  vad_hangover_smoother #(
    .ONSET_FRAMES(ONSET), .HANG_FRAMES(HANG), .SEG_W(3)
  ) dut_b (
    .clk(clk), .rst(rst),
    .tvalid_prediction(tvalid_prediction),
    .prediction(prediction),
    .vad_active(act_b), .vad_start(start_b),
    .vad_end(end_b), .seg_len(len_b)
  );

  // Reference: runs of positive/negative frames and an unbounded
  // segment length, clipped to the output range only when reported.
  bit m_in[2];
  bit m_s[2];
  bit m_e[2];
  int m_pos[2];
  int m_neg[2];
  int m_len[2];
  int m_seglen[2];
  int m_max[2];

  function void mstep(int k, bit r, bit tv, bit p);
    m_s[k] = 0;
    m_e[k] = 0;
    if (r) begin
      m_in[k] = 0; m_pos[k] = 0; m_neg[k] = 0;
      m_len[k] = 0; m_seglen[k] = 0;
      return;
    end
    if (!tv) return;
    if (!m_in[k]) begin
      if (p) begin
        m_pos[k]++;
        m_len[k]++;
        if (m_pos[k] == ONSET) begin
          m_in[k] = 1;
          m_s[k] = 1;
        end
      end else begin
        m_pos[k] = 0;
        m_len[k] = 0;
      end
    end else begin
      m_len[k]++;
      if (p) m_neg[k] = 0;
      else begin
        m_neg[k]++;
        if (m_neg[k] == HANG) begin
          m_e[k] = 1;
          m_seglen[k] = (m_len[k] > m_max[k]) ? m_max[k] : m_len[k];
          m_in[k] = 0; m_pos[k] = 0;
          m_neg[k] = 0; m_len[k] = 0;
        end
      end
    end
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick(bit r, bit tv, bit p);
    rst = r;
    tvalid_prediction = tv;
    prediction = p;
    @(posedge clk);
    mstep(0, r, tv, p);
    mstep(1, r, tv, p);
    #1;
    chk("model_a.active", int'(act_a), int'(m_in[0]));
    chk("model_a.start", int'(start_a), int'(m_s[0]));
    chk("model_a.end", int'(end_a), int'(m_e[0]));
    chk("model_a.seg_len", int'(len_a), m_seglen[0]);
    chk("model_b.active", int'(act_b), int'(m_in[1]));
    chk("model_b.start", int'(start_b), int'(m_s[1]));
    chk("model_b.end", int'(end_b), int'(m_e[1]));
    chk("model_b.seg_len", int'(len_b), m_seglen[1]);
  endtask

  typedef struct {
    bit r, tv, p;
    bit a, s, e;
    int len;
  } vec_t;

  vec_t tbl[$];

  function void v(bit r, bit tv, bit p, bit a, bit s, bit e, int len);
    vec_t x;
    x.r = r; x.tv = tv; x.p = p;
    x.a = a; x.s = s; x.e = e; x.len = len;
    tbl.push_back(x);
  endfunction

  bit cur;

  initial begin
    m_max[0] = 65535;
    m_max[1] = 7;
    rst = 1'b1;
    tvalid_prediction = 1'b0;
    prediction = 1'b0;

    // reset with strobes held, then 1,1,0 and idle toggling
    v(1,1,1, 0,0,0,0);
    v(1,1,1, 0,0,0,0);
    v(0,1,1, 0,0,0,0);
    v(0,1,1, 0,0,0,0);
    v(0,1,0, 0,0,0,0);
    v(0,0,1, 0,0,0,0);
    v(0,0,0, 0,0,0,0);
    v(0,0,1, 0,0,0,0);
    // onset 1,1,1 then speech, hang of 4 -> length 9
    v(0,1,1, 0,0,0,0);
    v(0,1,1, 0,0,0,0);
    v(0,1,1, 1,1,0,0);
    v(0,0,0, 1,0,0,0);
    v(0,1,1, 1,0,0,0);
    v(0,1,1, 1,0,0,0);
    v(0,1,0, 1,0,0,0);
    v(0,1,0, 1,0,0,0);
    v(0,0,1, 1,0,0,0);
    v(0,1,0, 1,0,0,0);
    v(0,1,0, 0,0,1,9);
    v(0,0,0, 0,0,0,9);
    // open, then 0,0,1,0,0,0,0 -> length 10
    v(0,1,1, 0,0,0,9);
    v(0,1,1, 0,0,0,9);
    v(0,1,1, 1,1,0,9);
    v(0,1,0, 1,0,0,9);
    v(0,1,0, 1,0,0,9);
    v(0,1,1, 1,0,0,9);
    v(0,1,0, 1,0,0,9);
    v(0,1,0, 1,0,0,9);
    v(0,1,0, 1,0,0,9);
    v(0,1,0, 0,0,1,10);
    v(0,0,1, 0,0,0,10);
    // reset while in HANG: no end pulse, length cleared
    v(0,1,1, 0,0,0,10);
    v(0,1,1, 0,0,0,10);
    v(0,1,1, 1,1,0,10);
    v(0,1,0, 1,0,0,10);
    v(1,1,0, 0,0,0,0);
    v(0,0,0, 0,0,0,0);
    v(0,1,1, 0,0,0,0);
    v(0,1,1, 0,0,0,0);
    v(0,1,1, 1,1,0,0);
    v(1,0,0, 0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].r, tbl[i].tv, tbl[i].p);
      chk($sformatf("vec%0d.active", i), int'(act_a), int'(tbl[i].a));
      chk($sformatf("vec%0d.start", i), int'(start_a), int'(tbl[i].s));
      chk($sformatf("vec%0d.end", i), int'(end_a), int'(tbl[i].e));
      chk($sformatf("vec%0d.seg_len", i), int'(len_a), tbl[i].len);
    end

    // 10 positives then 4 negatives: 14 frames, narrow counter saturates
    tick(1, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 1, 1);
    for (int i = 0; i < 4; i++) tick(0, 1, 0);
    chk("sat.end_b", int'(end_b), 1);
    chk("sat.len_b", int'(len_b), 7);
    chk("sat.len_a", int'(len_a), 14);

    // randomized runs with sticky predictions and rare resets
    cur = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) cur = ~cur;
      tick($urandom_range(0, 399) == 0,
           $urandom_range(0, 3) != 0,
           ($urandom_range(0, 11) == 0) ? ~cur : cur);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vad_hangover_smoother.md
Name: vad_hangover_smoother

Overview:
- Post-classifier decision stage. Consumes the per-frame speech/non-speech verdict (tvalid_prediction / prediction) produced by the MFCC + classifier pipeline.
- Applies onset confirmation and hangover hysteresis, so isolated misclassified frames neither open nor close a speech segment.
- Outputs a stable speech flag, one-cycle segment start/end events and the length of the closed segment. Runs on the fast system clock, beside the classifier.

Parameters:
- ONSET_FRAMES, 3, consecutive positive frames required to open a segment (>=1)
- HANG_FRAMES, 4, consecutive negative frames required to close a segment (>=1)
- SEG_W, 16, width of segment-length counter/output

Ports:
- clk  in  1  system clock (g_fast_clk domain)
- rst  in  1  synchronous, active-high reset
- tvalid_prediction  in  1  one-cycle strobe: prediction valid this cycle
- prediction  in  1  1 = speech frame, 0 = non-speech frame
- vad_active  out  1  smoothed speech flag
- vad_start  out  1  one-cycle pulse when a segment opens
- vad_end  out  1  one-cycle pulse when a segment closes
- seg_len  out  SEG_W  frame count of last closed segment; updated with vad_end, held otherwise

Behaviour:
- Only clk/rst are decided at the interface: one clock, reset synchronous and active-high.
- Reset: on rst=1 at a clk edge, state=IDLE, all counters=0, vad_active=0, vad_start=0, vad_end=0, seg_len=0. rst takes priority over any same-cycle tvalid_prediction.
- Reset mid-segment clears everything with no vad_end pulse.
- Frame sampling: prediction is sampled only when tvalid_prediction=1; otherwise it is ignored and no state changes. Back-to-back strobes on consecutive cycles are legal; each counts as one frame.
- Latency: all outputs are registered and reflect a frame one clk after its strobe cycle.
- Counters: onset_cnt and hang_cnt sized clog2(max+1). seg_cnt is SEG_W bits and saturates at 2^SEG_W-1 (no wrap).
- FSM states: IDLE, ONSET, SPEECH, HANG. Transitions are taken only on strobe cycles.
  - IDLE: pred=1 -> onset_cnt=1, seg_cnt=1. If ONSET_FRAMES==1, go to SPEECH and pulse vad_start; else go to ONSET. pred=0 -> stay in IDLE.
  - ONSET: pred=1 -> onset_cnt++ and seg_cnt++. When onset_cnt reaches ONSET_FRAMES, go to SPEECH and pulse vad_start. pred=0 -> IDLE, onset_cnt=0, seg_cnt=0, no pulse.
  - SPEECH: pred=1 -> seg_cnt++. pred=0 -> seg_cnt++, hang_cnt=1. If HANG_FRAMES==1, close (see below); else go to HANG.
  - HANG: pred=1 -> SPEECH, hang_cnt=0, seg_cnt++. pred=0 -> seg_cnt++, hang_cnt++. When hang_cnt reaches HANG_FRAMES, close.
- Close action: go to IDLE, pulse vad_end, seg_len<=seg_cnt (including this frame), then clear seg_cnt, hang_cnt and onset_cnt.
- vad_active: 1 in SPEECH and HANG; goes 1 in the same cycle as vad_start and 0 in the same cycle as vad_end.
- vad_start and vad_end each last exactly one cycle and are never asserted together.
- Any strobe landing in the same cycle as a pulse is processed normally.
- seg_len counts every frame from the first positive onset frame through the last hangover frame inclusive.

Test Plan:
- Reset with prediction=1 and tvalid_prediction=1 held during rst -> all outputs 0; first frame counted only after rst falls.
- Defaults; strobes with pred 1,1,0 -> no vad_start, vad_active stays 0, FSM back in IDLE. Toggling prediction while tvalid=0 causes no change.
- Pred 1,1,1 as back-to-back strobes -> vad_start high for exactly one cycle, one clk after the 3rd strobe; vad_active=1 from that cycle.
- Pred 1,1,1,1,1 then 0,0,0,0 -> vad_end pulse one clk after the 4th negative strobe, vad_active=0, seg_len=9.
- Open segment, then pred 0,0,1,0,0,0,0 -> no vad_end after the first two negatives; vad_end after the final 4 negatives; seg_len=3+7=10.
- rst asserted while in HANG -> vad_active=0 next clk, no vad_end, seg_len=0.
- SEG_W=3, 10 positives then 4 negatives -> seg_len saturates at 7.
